// File: rtl/debug_dump_unit.sv
// Host-side debug controller: takes UART command bytes, optionally steps the
// pipeline once, then streams a header plus PC, ALU, registers and memory words.
module debug_dump_unit #(
    parameter int NB          = 32,
    parameter int NB_REGS     = 5,
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 16,
    parameter int NB_BYTE     = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    input  logic [NB_BYTE-1:0] i_cmd,
    output logic               o_cmd_ready,
    output logic               o_step,
    output logic [NB_REGS-1:0] o_reg_number,
    output logic [NB-1:0]      o_debug_address,
    input  logic [NB-1:0]      i_mips_pc,
    input  logic [NB-1:0]      i_mips_alu_result,
    input  logic [NB-1:0]      i_mips_register_data,
    input  logic [NB-1:0]      i_mips_data_memory,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy
);

    localparam int N_ITEMS = 2 + N_REGS + N_MEM_WORDS;
    localparam int NB_ITEM = $clog2(N_ITEMS);

    localparam logic [NB_ITEM-1:0] FIRST_REG   = NB_ITEM'(2);
    localparam logic [NB_ITEM-1:0] FIRST_MEM   = NB_ITEM'(2 + N_REGS);
    localparam logic [NB_ITEM-1:0] LAST_ITEM   = NB_ITEM'(N_ITEMS - 1);
    localparam logic [NB_BYTE-1:0] CMD_STEP    = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_DUMP    = NB_BYTE'(8'h44);
    localparam logic [NB_BYTE-1:0] HEADER_BYTE = NB_BYTE'(8'hA5);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_HEADER,
        ST_SETTLE,
        ST_LOAD,
        ST_SEND
    } state_t;

    state_t              state_q, state_d;
    logic [NB_ITEM-1:0]  item_q, item_d;
    logic [1:0]          byte_q, byte_d;
    logic [NB-1:0]       shift_q, shift_d;
    logic [NB_ITEM-1:0]  reg_idx;
    logic [NB_ITEM-1:0]  mem_idx;
    logic [NB-1:0]       sel_word;
    logic                selecting;

    assign reg_idx   = item_q - FIRST_REG;
    assign mem_idx   = item_q - FIRST_MEM;
    assign selecting = (state_q == ST_SETTLE) || (state_q == ST_LOAD) || (state_q == ST_SEND);

    always_comb begin
        if (item_q == NB_ITEM'(0)) begin
            sel_word = i_mips_pc;
        end else if (item_q == NB_ITEM'(1)) begin
            sel_word = i_mips_alu_result;
        end else if (item_q < FIRST_MEM) begin
            sel_word = i_mips_register_data;
        end else begin
            sel_word = i_mips_data_memory;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            item_q  <= '0;
            byte_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            item_q  <= item_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
        end
    end

    // Outputs are decoded from registered state, so valid/data hold steady during a stall
    // and an asynchronous reset drops o_tx_valid without waiting for a clock edge.
    always_comb begin
        state_d         = state_q;
        item_d          = item_q;
        byte_d          = byte_q;
        shift_d         = shift_q;
        o_cmd_ready     = 1'b0;
        o_step          = 1'b0;
        o_tx_valid      = 1'b0;
        o_tx_data       = '0;
        o_reg_number    = '0;
        o_debug_address = '0;
        o_busy          = (state_q != ST_IDLE);

        if (selecting) begin
            if (item_q >= FIRST_MEM) begin
                o_debug_address = NB'({mem_idx, 2'b00});
            end else if (item_q >= FIRST_REG) begin
                o_reg_number = NB_REGS'(reg_idx);
            end
        end

        case (state_q)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                item_d      = '0;
                byte_d      = '0;
                if (i_cmd_valid) begin
                    if (i_cmd == CMD_STEP) begin
                        state_d = ST_STEP;
                    end else if (i_cmd == CMD_DUMP) begin
                        state_d = ST_HEADER;
                    end
                end
            end
            ST_STEP: begin
                o_step  = 1'b1;
                state_d = ST_HEADER;
            end
            ST_HEADER: begin
                o_tx_valid = 1'b1;
                o_tx_data  = HEADER_BYTE;
                if (i_tx_ready) begin
                    item_d  = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d = sel_word;
                byte_d  = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = shift_q[NB-1 -: NB_BYTE];
                if (i_tx_ready) begin
                    shift_d = shift_q << NB_BYTE;
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        if (item_q == LAST_ITEM) begin
                            item_d  = '0;
                            state_d = ST_IDLE;
                        end else begin
                            item_d  = item_q + NB_ITEM'(1);
                            state_d = ST_SETTLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
